logic_shift_unit: RTL and testbench
===================================

# logic_shift_unit

Parametrised, handshaked bitwise-logic and shift unit for the CPU execute stage. It generalises the combinational 32-bit inverter into a WIDTH-bit unit with eight operations: NOT, AND, OR, XOR, NOR, SLL, SRA and SRL. Bitwise operations complete in one cycle. Shifts run iteratively at one bit per cycle under a small FSM, with valid/ready handshakes on both the input and output sides. The unit sits beside the ALU adder and multiplier/divider and is stalled by the pipeline through `out_ready`.

## Interface
- `WIDTH`, default 32: datapath width; power of two, ≥ 8.
- `SHAMT_W`, default 5: shift-amount width; must equal log2(WIDTH).
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: an operation is presented.
- `in_ready` out 1: the unit accepts an operation this cycle.
- `op` in 3: 000 NOT a, 001 AND, 010 OR, 011 XOR, 100 NOR, 101 SLL, 110 SRA, 111 SRL.
- `data_a` in WIDTH: first operand; also the shift source.
- `data_b` in WIDTH: second operand; ignored for NOT and for shifts.
- `shamt` in SHAMT_W: shift amount; ignored for non-shift ops.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: the consumer takes the result.
- `result` out WIDTH: registered result.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - SHIFT: iterating.
  - DONE: `out_valid`=1.
- Accept condition: `in_valid && in_ready`. On accept, `op`, `data_a`, `data_b` and `shamt` are captured internally. Later input changes have no effect.
- Bitwise ops (000–100): the result is computed from the captured operands and registered. IDLE→DONE.
- Shifts with `shamt`=0: the result is `data_a`. IDLE→DONE.
- Shifts with `shamt`≠0: the working register loads `data_a` and the counter loads `shamt`. IDLE→SHIFT.
  - In SHIFT, each cycle shifts one bit and decrements the counter:
    - SLL: zero in at the LSB.
    - SRL: zero in at the MSB.
    - SRA: the MSB is replicated.
  - When the counter reaches 1, that final shift is performed and the FSM moves SHIFT→DONE.
- DONE: `result` and `out_valid` are held stable until `out_ready`=1. Then DONE→IDLE on that edge.
  - There is no same-cycle re-accept: `in_ready` is 0 in DONE.
- `in_valid` is ignored while `in_ready`=0. No operation is queued.
- Illegal states recover to IDLE.

## Timing
- Reset values:
  - `out_valid`=0, `result`=0, `busy`=0.
  - FSM=IDLE; internal registers are 0.
  - `in_ready` is forced to 0 while `reset_n`=0 and is 1 from the first cycle after release.
- Reset takes effect immediately and asynchronously, including mid-SHIFT or in DONE. The in-flight operation is discarded with no output.
- Latency, from the accept edge to the first cycle with `out_valid`=1:
  - Bitwise ops and shifts with `shamt`=0: 1 cycle.
  - Other shifts: `shamt`+1 cycles. The maximum is WIDTH cycles.
- Throughput:
  - With `out_ready` held at 1, one bitwise op completes every 2 cycles (accept, DONE).
  - A shift by n completes every n+2 cycles.
- `busy` = (state ≠ IDLE). `in_ready` = (state = IDLE) && `reset_n`.
- Outputs are registered. There is no combinational path from the inputs to `result` or `out_valid`.

## Configuration
- `LU_BARREL_EN`
  - Defined: shifts are computed by a single-cycle barrel shifter, so every op has 1-cycle latency. SHIFT is unreachable and the counter is removed.
  - Undefined: shifts use the iterative path described above.
- The function, the handshake and the reset behaviour are identical in both builds. Only the shift latency differs.

## Test plan
- NOT, `data_a`=0x0F0F0000 → `result`=0xF0F0FFFF; `out_valid` rises 1 cycle after accept.
- XOR, `data_a`=0xFFFF0000, `data_b`=0x0FF00FF0 → 0xF00F0FF0. NOR of 0 and 0 → 0xFFFFFFFF.
- SRA, `data_a`=0x80000000, `shamt`=4 → 0xF8000000 at latency 5 (1 with `LU_BARREL_EN`). SRL with the same operands → 0x08000000.
- SLL, `data_a`=0x12345678, `shamt`=0 → 0x12345678 at latency 1. SLL with `shamt`=31, `data_a`=1 → 0x80000000 at latency 32.
- Backpressure: complete an AND with `out_ready`=0 for 3 cycles → `result` stable, `in_ready`=0, and a new `in_valid` is ignored. On `out_ready`=1 → IDLE next cycle.
- Start SLL with `shamt`=31 and assert `reset_n`=0 at cycle 10 → immediately `out_valid`=0, `result`=0, `busy`=0. After release, `in_ready`=1 and a fresh NOT completes correctly.

Source files
------------

// File: rtl/logic_shift_unit_if.sv
// logic_shift_unit_if: operation/result handshake bundle for logic_shift_unit
interface logic_shift_unit_if #(parameter int WIDTH = 32, parameter int SHAMT_W = 5);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0] op;
  logic [WIDTH-1:0] data_a, data_b, result;
  logic [SHAMT_W-1:0] shamt;
  modport master(output in_valid, op, data_a, data_b, shamt, out_ready, input in_ready, out_valid, result, busy);
  modport slave(input in_valid, op, data_a, data_b, shamt, out_ready, output in_ready, out_valid, result, busy);
endinterface

// File: rtl/logic_shift_unit.sv
// logic_shift_unit: handshaked NOT/AND/OR/XOR/NOR/SLL/SRA/SRL unit; LU_BARREL_EN selects single-cycle shifts
module logic_shift_unit #(parameter int WIDTH = 32, parameter int SHAMT_W = 5) (
  input logic clock,
  input logic reset_n,
  logic_shift_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, next_state;
  logic acc, start_shift, last;
  logic [WIDTH-1:0] a, b, imm, shift_res, step, result;
  assign a = bus.data_a;
  assign b = bus.data_b;
  assign acc = bus.in_valid && bus.in_ready;
`ifdef LU_BARREL_EN
  logic signed [WIDTH-1:0] sra_res;
  assign sra_res = $signed(a) >>> bus.shamt;
  assign shift_res = bus.op == 3'd5 ? a << bus.shamt : bus.op == 3'd6 ? sra_res : a >> bus.shamt;
  assign start_shift = 1'b0;
  assign last = 1'b1;
  assign step = result;
`else
  logic [2:0] op_q;
  logic [WIDTH-1:0] work;
  logic [SHAMT_W-1:0] cnt;
  assign shift_res = a;
  assign start_shift = bus.op >= 3'd5 && |bus.shamt;
  assign last = cnt == SHAMT_W'(1);
  assign step = op_q == 3'd5 ? {work[WIDTH-2:0], 1'b0} : {op_q == 3'd6 && work[WIDTH-1], work[WIDTH-1:1]};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      op_q <= '0;
      work <= '0;
      cnt <= '0;
    end else if (acc) begin
      op_q <= bus.op;
      work <= a;
      cnt <= bus.shamt;
    end else if (state == SHIFT) begin
      work <= step;
      cnt <= cnt - 1'b1;
    end
`endif
  assign imm = bus.op == 3'd0 ? ~a :
               bus.op == 3'd1 ? a & b :
               bus.op == 3'd2 ? a | b :
               bus.op == 3'd3 ? a ^ b :
               bus.op == 3'd4 ? ~(a | b) : shift_res;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next_state;
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: next_state = acc ? (start_shift ? SHIFT : DONE) : IDLE;
      SHIFT: next_state = last ? DONE : SHIFT;
      DONE: next_state = bus.out_ready ? IDLE : DONE;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready = state == IDLE && reset_n;
    bus.out_valid = state == DONE;
    bus.busy = state != IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) result <= '0;
    else if (acc && !start_shift) result <= imm;
    else if (state == SHIFT && last) result <= step;
  assign bus.result = result;
endmodule

// File: tb/tb_logic_shift_unit.sv
// tb_logic_shift_unit: directed-vector bench for logic_shift_unit (either LU_BARREL_EN build)
module tb_logic_shift_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int errors = 0;
  logic_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus();
  logic_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;

  function automatic int slat(input int sh);
`ifdef LU_BARREL_EN
    return 1;
`else
    return sh == 0 ? 1 : sh + 1;
`endif
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clock);
    bus.op = op; bus.data_a = a; bus.data_b = b; bus.shamt = sh;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0; bus.op = op ^ 3'd1; bus.data_a = ~a; bus.data_b = ~b; bus.shamt = ~sh;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    vectors++;
    if (bus.result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", name, bus.result, exp);
    end
    vectors++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    @(posedge clock); #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: in_ready=%b out_valid=%b expected 1/0", name, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0;
    bus.data_a = '0; bus.data_b = '0; bus.shamt = '0;
    #12;
    vectors++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL reset flags: out_valid/busy/in_ready=%b expected 000", {bus.out_valid, bus.busy, bus.in_ready});
    end
    vectors++;
    if (bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset result: got %h expected 00000000", bus.result);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset release: in_ready=%b busy=%b expected 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_bitwise;
    run_op("NOT", 3'd0, 32'h0F0F0000, 32'h12345678, 5'd3, 32'hF0F0FFFF, 1);
    run_op("AND", 3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 5'd7, 32'hF000F000, 1);
    run_op("OR", 3'd2, 32'h12340000, 32'h00005678, 5'd0, 32'h12345678, 1);
    run_op("XOR", 3'd3, 32'hFFFF0000, 32'h0FF00FF0, 5'd1, 32'hF00F0FF0, 1);
    run_op("NOR", 3'd4, 32'h00000000, 32'h00000000, 5'd0, 32'hFFFFFFFF, 1);
  endtask

  task automatic test_shifts;
    run_op("SRA neg", 3'd6, 32'h80000000, 32'h0, 5'd4, 32'hF8000000, slat(4));
    run_op("SRL", 3'd7, 32'h80000000, 32'h0, 5'd4, 32'h08000000, slat(4));
    run_op("SRA pos", 3'd6, 32'h40000000, 32'h0, 5'd3, 32'h08000000, slat(3));
    run_op("SLL 4", 3'd5, 32'h12345678, 32'h0, 5'd4, 32'h23456780, slat(4));
    run_op("SLL 0", 3'd5, 32'h12345678, 32'h0, 5'd0, 32'h12345678, 1);
    run_op("SLL 31", 3'd5, 32'h00000001, 32'h0, 5'd31, 32'h80000000, slat(31));
  endtask

  task automatic test_backpressure;
    @(negedge clock);
    bus.op = 3'd1; bus.data_a = 32'hF0F0F0F0; bus.data_b = 32'hFF00FF00; bus.shamt = '0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clock); #1;
    bus.op = 3'd0; bus.data_a = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'hF000F000) begin
        errors++;
        $display("FAIL stall cycle %0d: out_valid=%b in_ready=%b result=%h expected 1/0/f000f000",
                 i, bus.out_valid, bus.in_ready, bus.result);
      end
    end
    @(negedge clock);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall release: out_valid=%b in_ready=%b busy=%b expected 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    end
    vectors++;
    if (bus.result !== 32'hF000F000) begin
      errors++;
      $display("FAIL stall ignored input: result=%h expected f000f000", bus.result);
    end
  endtask

  task automatic test_back_to_back;
    int seen = 0;
    @(negedge clock);
    bus.op = 3'd0; bus.data_a = 32'hAAAAAAAA; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (seen !== 3) begin
      errors++;
      $display("FAIL back_to_back count: got %0d expected 3", seen);
    end
    vectors++;
    if (bus.result !== 32'h55555555) begin
      errors++;
      $display("FAIL back_to_back result: got %h expected 55555555", bus.result);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_shift;
    @(negedge clock);
    bus.op = 3'd5; bus.data_a = 32'h1; bus.shamt = 5'd31; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #2;
`ifndef LU_BARREL_EN
    vectors++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_shift busy: got %b expected 1", bus.busy);
    end
`endif
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL mid_shift reset flags: out_valid/busy/in_ready=%b expected 000", {bus.out_valid, bus.busy, bus.in_ready});
    end
    vectors++;
    if (bus.result !== 32'h0) begin
      errors++;
      $display("FAIL mid_shift reset result: got %h expected 00000000", bus.result);
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_shift release: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    run_op("NOT after reset", 3'd0, 32'h0000FFFF, 32'h0, 5'd0, 32'hFFFF0000, 1);
  endtask

  initial begin
    test_reset();
    test_bitwise();
    test_shifts();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
